catch_surucu: RTL

CATCH_SURUCU -- requirements
Module: catch_surucu

---
 rtl/catch_pkg.sv | 47 ++++
 rtl/catch_lfsr.sv | 33 +++
 rtl/catch_surucu.sv | 119 +++++++++++
 3 files changed

// File: rtl/catch_pkg.sv
// ============================================================================
// catch_pkg: direction codes, FSM state type, start positions and move helper
// shared by the catch_surucu driver and its LFSR.
// Revision: 1.0
// ============================================================================
`default_nettype none

package catch_pkg;

   typedef logic [1:0] yon_t;

   localparam yon_t YUKARI = 2'd0;
   localparam yon_t ASAGI  = 2'd1;
   localparam yon_t SOL    = 2'd2;
   localparam yon_t SAG    = 2'd3;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      KOS   = 2'd1,
      BITTI = 2'd2
   } st_t;

   typedef struct packed {
      logic [1:0] x;
      logic [1:0] y;
   } konum_t;

   localparam konum_t c_p1_bas = '{x: 2'd3, y: 2'd3};
   localparam konum_t c_p2_bas = '{x: 2'd0, y: 2'd0};

   // One step on the 4x4 board; moves off the edge leave the position unchanged.
   function automatic konum_t hareket(konum_t p, yon_t d);
      konum_t n;
      n = p;
      case (d)
         YUKARI:  if (p.y != 2'd3) n.y = p.y + 2'd1;
         ASAGI:   if (p.y != 2'd0) n.y = p.y - 2'd1;
         SOL:     if (p.x != 2'd3) n.x = p.x + 2'd1;
         SAG:     if (p.x != 2'd0) n.x = p.x - 2'd1;
         default: n = p;
      endcase
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/catch_lfsr.sv
// ============================================================================
// catch_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), advances when enabled.
// Revision: 1.0
// ============================================================================
`default_nettype none

module catch_lfsr #(
   parameter logic [7:0] TOHUM = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   output logic [7:0] o_lfsr
);

   logic [7:0] r_lfsr;
   logic       w_geri;

   assign w_geri = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= TOHUM;
      end else if (i_en) begin
         r_lfsr <= {r_lfsr[6:0], w_geri};
      end
   end

   assign o_lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/catch_surucu.sv
// ============================================================================
// catch_surucu: drives both players of the catch game; optional LFSR runner
// strategy enabled by macro CATCH_SURUCU_LFSR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module catch_surucu
   import catch_pkg::*;
#(
   parameter int         HEDEF      = 4,
   parameter int         MAKS_ADIM  = 200,
   parameter logic [7:0] LFSR_TOHUM = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       basla,
   input  logic       durum,
   output logic [3:0] yon,
   output logic       mesgul,
   output logic       bitti,
   output logic       zaman_asimi,
   output logic [3:0] yakalanan
);

   localparam logic [3:0] c_hedef_son = 4'(HEDEF - 1);
   localparam logic [7:0] c_adim_son  = 8'(MAKS_ADIM - 1);

   st_t        r_st;
   st_t        w_st_nxt;
   konum_t     r_p1;
   konum_t     r_p2;
   logic [7:0] r_adim;
   logic [3:0] r_yakalanan;
   logic       r_zaman_asimi;
   logic       w_hedef_tamam;
   logic       w_sure_doldu;
   logic       w_kos_gir;
   yon_t       w_kacan;
   yon_t       w_kovalayan;

`ifdef CATCH_SURUCU_LFSR_EN
   logic [7:0] w_lfsr;

   catch_lfsr #(
      .TOHUM (LFSR_TOHUM)
   ) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .i_en   (r_st == KOS),
      .o_lfsr (w_lfsr)
   );

   assign w_kacan = w_lfsr[1:0];
`else
   assign w_kacan = YUKARI;
`endif

   assign w_hedef_tamam = (r_st == KOS) && durum && (r_yakalanan == c_hedef_son);
   assign w_sure_doldu  = (r_st == KOS) && (r_adim == c_adim_son);
   assign w_kos_gir     = (r_st != KOS) && (w_st_nxt == KOS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_st <= BOSTA;
      end else begin
         r_st <= w_st_nxt;
      end
   end

   always_comb begin
      w_st_nxt    = r_st;
      w_kovalayan = YUKARI;
      yon         = {YUKARI, ASAGI};
      case (r_st)
         BOSTA:   if (basla) w_st_nxt = KOS;
         KOS:     if (w_hedef_tamam || w_sure_doldu) w_st_nxt = BITTI;
         BITTI:   if (basla) w_st_nxt = KOS;
         default: w_st_nxt = BOSTA;
      endcase
      if      (r_p2.x < r_p1.x) w_kovalayan = SOL;
      else if (r_p2.x > r_p1.x) w_kovalayan = SAG;
      else if (r_p2.y < r_p1.y) w_kovalayan = YUKARI;
      else if (r_p2.y > r_p1.y) w_kovalayan = ASAGI;
      if (r_st == KOS) yon = {w_kacan, w_kovalayan};
   end

   // Mirrors track the game block every cycle, whatever the FSM state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p1          <= c_p1_bas;
         r_p2          <= c_p2_bas;
         r_adim        <= 8'd0;
         r_yakalanan   <= 4'd0;
         r_zaman_asimi <= 1'b0;
      end else begin
         r_p1 <= hareket(r_p1, yon[3:2]);
         r_p2 <= hareket(r_p2, yon[1:0]);
         if (w_kos_gir) begin
            r_adim        <= 8'd0;
            r_yakalanan   <= 4'd0;
            r_zaman_asimi <= 1'b0;
         end else if (r_st == KOS) begin
            r_adim <= r_adim + 8'd1;
            if (durum && (r_yakalanan != 4'd15)) r_yakalanan <= r_yakalanan + 4'd1;
            if (w_hedef_tamam)     r_zaman_asimi <= 1'b0;
            else if (w_sure_doldu) r_zaman_asimi <= 1'b1;
         end
      end
   end

   assign mesgul      = (r_st == KOS);
   assign bitti       = (r_st == BITTI);
   assign zaman_asimi = r_zaman_asimi && (r_st == BITTI);
   assign yakalanan   = r_yakalanan;

endmodule

`default_nettype wire
